// File: rtl/stream_out_queue.sv
// Transmitter end of the d/e/v/b page stream: buffers core tokens, drives the link, tracks EOS.
// Optional token counter enabled by defining STREAM_OUT_QUEUE_STATS_EN.
module stream_out_queue #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_e,
  input  logic             in_v,
  output logic             in_b,
  output logic [WIDTH-1:0] out_d,
  output logic             out_e,
  output logic             out_v,
  input  logic             out_b,
  output logic             closed,
  output logic             proto_err,
  output logic [15:0]      tok_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH  = (AW+1)'(DEPTH - SLACK);

  typedef enum logic [1:0] {OPEN, DRAIN, CLOSED} state_t;

  state_t          state, state_next;
  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [AW:0]     count, count_after_pop, count_next;
  logic            pop, push_ok, drop;
  logic [WIDTH:0]  head_next;
  logic            out_v_next;

  // count includes the token currently presented on out_*, so the out
  // register always mirrors the queue head rather than being an extra stage.
  always_comb begin
    pop             = out_v && !out_b;
    push_ok         = in_v && (state == OPEN) && ((count != DEPTH_C) || pop);
    drop            = in_v && !push_ok;
    count_after_pop = count - (AW+1)'(pop);
    count_next      = count_after_pop + (AW+1)'(push_ok);
    rd_ptr_next     = rd_ptr + AW'(pop);
    head_next       = mem[rd_ptr_next];
    if (count_after_pop == '0 && push_ok)
      head_next = {in_e, in_d};
    state_next = state;
    case (state)
      OPEN:    if (push_ok && in_e) state_next = DRAIN;
      DRAIN:   if (pop && out_e)    state_next = CLOSED;
      default: state_next = state;
    endcase
    out_v_next = (count_next != '0) && (state_next != CLOSED);
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= {in_e, in_d};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= OPEN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_v     <= 1'b0;
      out_d     <= '0;
      out_e     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      out_v  <= out_v_next;
      if (out_v_next) begin
        out_d <= head_next[WIDTH-1:0];
        out_e <= head_next[WIDTH];
      end
      if (drop)
        proto_err <= 1'b1;
    end
  end

  // Held high through reset so the core never pushes into a flushing queue.
  assign in_b   = !reset || (count >= THRESH) || (state != OPEN);
  assign closed = (state == CLOSED);

`ifdef STREAM_OUT_QUEUE_STATS_EN
  logic [15:0] tok_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      tok_q <= '0;
    else if (pop && !out_e && tok_q != 16'hFFFF)
      tok_q <= tok_q + 16'd1;
  end

  assign tok_count = tok_q;
`else
  assign tok_count = '0;
`endif

endmodule
